router_xbar: RTL and testbench

- Parametrised successor to the single-path router top.
- NPORTS serial input ports, each decoded by the existing portin block into a 4-bit address and a 32-bit payload.
- A per-output round-robin arbiter routes each packet to the output queue selected by its address. Output queues are the existing fifo; serial output is the existing portout.
- Adds true any-to-any switching, contention arbitration, invalid-address and overflow dropping, and a drop counter. The single-path design has none of these.

---
 rtl/router_pkg.sv | 38 +++
 rtl/router_xbar_if.sv | 12 +
 rtl/fifo.sv | 51 +++++
 rtl/portin.sv | 45 ++++
 rtl/portout.sv | 37 +++
 rtl/router_rr_arb.sv | 28 ++
 rtl/router_xbar.sv | 127 ++++++++++++
 tb/tb_router_xbar.sv | 284 ++++++++++++++++++++++++++++
 8 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths, packet type and round-robin pick helper for router_xbar
package router_pkg;

    localparam int ADDR_W    = 4;
    localparam int PAYLOAD_W = 32;
    localparam int PKT_W     = ADDR_W + PAYLOAD_W;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [PAYLOAD_W-1:0] payload;
    } pkt_t;

    typedef struct packed {
        logic              found;
        logic [ADDR_W-1:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping modulo n (n <= 16, ptr < n).
    function automatic pick_t rr_pick(input logic [15:0] req,
                                      input logic [ADDR_W-1:0] ptr,
                                      input int unsigned n);
        pick_t             r;
        int unsigned       j;
        logic [ADDR_W-1:0] j4;
        r = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            j = 32'(ptr) + k;
            if (j >= n) j = j - n;
            j4 = j[ADDR_W-1:0];
            if (k < n && !r.found && req[j4]) begin
                r.found = 1'b1;
                r.idx   = j4;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/router_xbar_if.sv
// rtl/router_xbar_if.sv - serial input/output strobes and data of all router_xbar ports
interface router_xbar_if #(parameter int NPORTS = 8);
    logic [NPORTS-1:0] frame_n;
    logic [NPORTS-1:0] valid_n;
    logic [NPORTS-1:0] di;
    logic [NPORTS-1:0] dout;
    logic [NPORTS-1:0] valido_n;
    logic [NPORTS-1:0] frameo_n;

    modport master (output frame_n, valid_n, di, input dout, valido_n, frameo_n);
    modport slave  (input frame_n, valid_n, di, output dout, valido_n, frameo_n);
endinterface

// File: rtl/fifo.sv
// rtl/fifo.sv - show-ahead synchronous fifo, DEPTH a power of 2
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rptr];

    // Pointers and occupancy; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end
endmodule

// File: rtl/portin.sv
// rtl/portin.sv - serial deserialiser: 36 valid bits LSB first (4-bit addr then 32-bit payload)
module portin import router_pkg::*; (
    input  logic clk,
    input  logic rst_n,
    input  logic i_frame_n,
    input  logic i_valid_n,
    input  logic i_di,
    output logic o_vld,
    output pkt_t o_pkt
);
    logic [PKT_W-2:0] r_sh;
    logic [5:0]       r_cnt;
    logic             r_vld;
    pkt_t             r_pkt;
    logic [PKT_W-1:0] w_word;

    assign w_word = {i_di, r_sh};
    assign o_vld  = r_vld;
    assign o_pkt  = r_pkt;

    // Shift in bits while framed and valid; pulse vld for one cycle after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
            r_pkt <= '0;
        end else begin
            r_vld <= 1'b0;
            if (i_frame_n) begin
                r_cnt <= '0;
            end else if (!i_valid_n) begin
                r_sh <= w_word[PKT_W-1:1];
                if (r_cnt == 6'(PKT_W-1)) begin
                    r_cnt         <= '0;
                    r_vld         <= 1'b1;
                    r_pkt.addr    <= w_word[ADDR_W-1:0];
                    r_pkt.payload <= w_word[PKT_W-1:ADDR_W];
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end
        end
    end
endmodule

// File: rtl/portout.sv
// rtl/portout.sv - serialiser: pops one payload, then 32 bits LSB first with frameo_n/valido_n low
module portout import router_pkg::*; (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_empty,
    input  logic [PAYLOAD_W-1:0] i_data,
    output logic                 o_pop,
    output logic                 o_dout,
    output logic                 o_valid_n,
    output logic                 o_frame_n
);
    logic                 r_busy;
    logic [PAYLOAD_W-1:0] r_sh;
    logic [4:0]           r_cnt;

    assign o_pop     = !r_busy && !i_empty;
    assign o_dout    = r_busy & r_sh[0];
    assign o_valid_n = ~r_busy;
    assign o_frame_n = ~r_busy;

    // Load on pop, then shift out one bit per cycle until all 32 are sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_sh   <= '0;
            r_cnt  <= '0;
        end else if (o_pop) begin
            r_busy <= 1'b1;
            r_sh   <= i_data;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_sh  <= r_sh >> 1;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/router_rr_arb.sv
// rtl/router_rr_arb.sv - per-output arbiter; round-robin, or fixed priority with ROUTER_FIXED_PRIO_EN
module router_rr_arb import router_pkg::*; #(
    parameter int NPORTS = 8
) (
`ifndef ROUTER_FIXED_PRIO_EN
    input  logic [ADDR_W-1:0] i_ptr,
`endif
    input  logic [NPORTS-1:0] i_req,
    output logic [NPORTS-1:0] o_gnt,
    output logic [ADDR_W-1:0] o_win,
    output logic              o_found
);
    pick_t w_pick;

    // Search from the pointer (or from input 0) and expose winner as index and one-hot.
    always_comb begin
`ifdef ROUTER_FIXED_PRIO_EN
        w_pick = rr_pick(16'(i_req), '0, NPORTS);
`else
        w_pick = rr_pick(16'(i_req), i_ptr, NPORTS);
`endif
        o_win   = w_pick.idx;
        o_found = w_pick.found;
        for (int i = 0; i < NPORTS; i++) begin
            o_gnt[i] = w_pick.found && (w_pick.idx == ADDR_W'(i));
        end
    end
endmodule

// File: rtl/router_xbar.sv
// rtl/router_xbar.sv - NPORTS x NPORTS serial packet crossbar with drop counter; ROUTER_FIXED_PRIO_EN selects fixed-priority arbitration
module router_xbar import router_pkg::*; #(
    parameter int NPORTS     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    router_xbar_if.slave      bus,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam logic [ADDR_W:0] NP_L = (ADDR_W+1)'(NPORTS);

    logic [NPORTS-1:0]    w_vld, r_hvld, w_in_gnt, w_drop;
    logic [NPORTS-1:0]    w_full, w_empty, w_pop, w_found;
    logic [NPORTS-1:0]    w_dout, w_valido_n, w_frameo_n;
    pkt_t                 w_pkt  [NPORTS];
    pkt_t                 r_hold [NPORTS];
    logic [NPORTS-1:0]    w_req  [NPORTS];
    logic [NPORTS-1:0]    w_gnt  [NPORTS];
    logic [ADDR_W-1:0]    w_win  [NPORTS];
    logic [PAYLOAD_W-1:0] w_din  [NPORTS];
    logic [PAYLOAD_W-1:0] w_fdout[NPORTS];
    logic [ADDR_W:0]      w_pc;
    logic [DROP_W:0]      w_sum;
    logic [DROP_W-1:0]    r_drop;
`ifndef ROUTER_FIXED_PRIO_EN
    logic [ADDR_W-1:0]    r_ptr  [NPORTS];
`endif

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        portin u_portin (
            .clk(clock), .rst_n(reset_n),
            .i_frame_n(bus.frame_n[g]), .i_valid_n(bus.valid_n[g]), .i_di(bus.di[g]),
            .o_vld(w_vld[g]), .o_pkt(w_pkt[g])
        );
        router_rr_arb #(.NPORTS(NPORTS)) u_arb (
`ifndef ROUTER_FIXED_PRIO_EN
            .i_ptr(r_ptr[g]),
`endif
            .i_req(w_req[g]), .o_gnt(w_gnt[g]), .o_win(w_win[g]), .o_found(w_found[g])
        );
        fifo #(.W(PAYLOAD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clock), .rst_n(reset_n),
            .i_push(w_found[g]), .i_din(w_din[g]), .i_pop(w_pop[g]),
            .o_dout(w_fdout[g]), .o_full(w_full[g]), .o_empty(w_empty[g])
        );
        portout u_portout (
            .clk(clock), .rst_n(reset_n),
            .i_empty(w_empty[g]), .i_data(w_fdout[g]), .o_pop(w_pop[g]),
            .o_dout(w_dout[g]), .o_valid_n(w_valido_n[g]), .o_frame_n(w_frameo_n[g])
        );
    end

    assign bus.dout     = w_dout;
    assign bus.valido_n = w_valido_n;
    assign bus.frameo_n = w_frameo_n;
    assign drop_cnt     = r_drop;

    // A held packet requests its destination only while that fifo has room.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                w_req[o][i] = r_hvld[i] && (r_hold[i].addr == ADDR_W'(o)) && !w_full[o];
            end
        end
    end

    // Merge grants per input, mux winner payloads, and find this cycle's drops.
    always_comb begin
        w_in_gnt = '0;
        w_pc     = '0;
        for (int o = 0; o < NPORTS; o++) begin
            w_din[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                w_in_gnt[i] = w_in_gnt[i] | w_gnt[o][i];
                w_din[o]    = w_din[o] | ({PAYLOAD_W{w_gnt[o][i]}} & r_hold[i].payload);
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            w_drop[i] = w_vld[i] && (({1'b0, w_pkt[i].addr} >= NP_L) || (r_hvld[i] && !w_in_gnt[i]));
            w_pc      = w_pc + (ADDR_W+1)'(w_drop[i]);
        end
        w_sum = {1'b0, r_drop} + (DROP_W+1)'(w_pc);
    end

    // Hold registers: a granted slot may be refilled in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hvld <= '0;
            for (int i = 0; i < NPORTS; i++) r_hold[i] <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_vld[i] && !w_drop[i]) begin
                    r_hvld[i] <= 1'b1;
                    r_hold[i] <= w_pkt[i];
                end else if (w_in_gnt[i]) begin
                    r_hvld[i] <= 1'b0;
                end
            end
        end
    end

`ifndef ROUTER_FIXED_PRIO_EN
    // Round-robin pointers move just past each winner.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < NPORTS; o++) r_ptr[o] <= '0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (w_found[o]) begin
                    r_ptr[o] <= (w_win[o] == ADDR_W'(NPORTS-1)) ? '0 : w_win[o] + 1'b1;
                end
            end
        end
    end
`endif

    // Saturating drop counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= '0;
        end else begin
            r_drop <= w_sum[DROP_W] ? '1 : w_sum[DROP_W-1:0];
        end
    end
endmodule

// File: tb/tb_router_xbar.sv
// tb/tb_router_xbar.sv - randomized scoreboard bench for router_xbar with a packet-level reference model
module tb_router_xbar;
    import router_pkg::*;

    localparam int NP = 8;
    localparam int FD = 2;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] drop_cnt;

    router_xbar_if #(.NPORTS(NP)) bus ();

    router_xbar #(.NPORTS(NP), .FIFO_DEPTH(FD), .DROP_W(DW)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct { int cyc; int addr; logic [31:0] pay; } cap_t;
    typedef struct { logic [31:0] pay; int start; } exp_t;

    cap_t        capq [NP][$];
    exp_t        expq [NP][$];
    bit          m_hvld [NP];
    int          m_haddr[NP];
    logic [31:0] m_hpay [NP];
    logic [31:0] m_fifo [NP][$];
    int          m_ptr  [NP];
    int          m_left [NP];
    int          m_drop;

    bit          s_en  [NP];
    int          s_addr[NP];
    logic [31:0] s_pay [NP];
    int          s_off [NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: per-cycle packet rules on queues, stepped at each rising edge.
    always @(posedge clock) begin : p_model
        int  win [NP];
        bit  gnt [NP];
        bit  pop [NP];
        int  drops, st, j;
        cap_t c;
        if (!reset_n) begin
            for (int i = 0; i < NP; i++) begin
                capq[i].delete(); expq[i].delete(); m_fifo[i].delete();
                m_hvld[i] = 0; m_ptr[i] = 0; m_left[i] = 0;
            end
            m_drop = 0;
        end else begin
            for (int i = 0; i < NP; i++) gnt[i] = 0;
            for (int o = 0; o < NP; o++) begin
                win[o] = -1;
`ifdef ROUTER_FIXED_PRIO_EN
                st = 0;
`else
                st = m_ptr[o];
`endif
                for (int k = 0; k < NP; k++) begin
                    j = (st + k) % NP;
                    if (win[o] < 0 && m_hvld[j] && m_haddr[j] == o && m_fifo[o].size() < FD) win[o] = j;
                end
                if (win[o] >= 0) gnt[win[o]] = 1;
                pop[o] = (m_left[o] == 0) && (m_fifo[o].size() > 0);
            end
            for (int o = 0; o < NP; o++) begin
                if (pop[o]) begin
                    expq[o].push_back('{m_fifo[o].pop_front(), cyc + 1});
                    m_left[o] = 32;
                end else if (m_left[o] > 0) begin
                    m_left[o]--;
                end
                if (win[o] >= 0) begin
                    m_fifo[o].push_back(m_hpay[win[o]]);
                    m_ptr[o] = (win[o] + 1) % NP;
                end
            end
            drops = 0;
            for (int i = 0; i < NP; i++) begin
                if (gnt[i]) m_hvld[i] = 0;
                if (capq[i].size() > 0 && capq[i][0].cyc == cyc) begin
                    c = capq[i].pop_front();
                    if (c.addr >= NP || m_hvld[i]) drops++;
                    else begin
                        m_hvld[i] = 1; m_haddr[i] = c.addr; m_hpay[i] = c.pay;
                    end
                end
            end
            m_drop = (m_drop + drops > 2**DW - 1) ? 2**DW - 1 : m_drop + drops;
        end
        cyc++;
    end

    // Monitor: deserialise each output and compare against the scoreboard.
    always @(negedge clock) begin : p_mon
        logic [31:0] sh [NP];
        int          nb [NP];
        int          st [NP];
        exp_t        e;
        if (!reset_n) begin
            for (int o = 0; o < NP; o++) nb[o] = 0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (bus.valido_n[o] == 1'b0) begin
                    if (nb[o] == 0) st[o] = cyc;
                    sh[o][nb[o]] = bus.dout[o];
                    nb[o]++;
                    if (nb[o] == 32) begin
                        nb[o] = 0;
                        if (expq[o].size() == 0) begin
                            n_chk++;
                            $display("FAIL unexpected_frame out%0d: got 0x%0h, expected no frame", o, sh[o]);
                        end else begin
                            e = expq[o].pop_front();
                            chk($sformatf("payload_out%0d", o), 64'(sh[o]), 64'(e.pay));
                            chk($sformatf("start_cycle_out%0d", o), 64'(st[o]), 64'(e.start));
                        end
                    end
                end
            end
        end
    end

    task automatic clear_set();
        for (int i = 0; i < NP; i++) begin
            s_en[i] = 0; s_addr[i] = 0; s_pay[i] = '0; s_off[i] = 0;
        end
    endtask

    task automatic send_set();
        int          maxoff = 0;
        int          k;
        logic [35:0] w;
        for (int i = 0; i < NP; i++) if (s_en[i] && s_off[i] > maxoff) maxoff = s_off[i];
        for (int s = 0; s < 36 + maxoff; s++) begin
            @(negedge clock);
            for (int i = 0; i < NP; i++) begin
                k = s - s_off[i];
                if (s_en[i] && k >= 0 && k < 36) begin
                    w = {s_pay[i], 4'(s_addr[i])};
                    bus.frame_n[i] = 1'b0;
                    bus.valid_n[i] = 1'b0;
                    bus.di[i]      = w[k];
                    if (k == 35) capq[i].push_back('{cyc + 1, s_addr[i], s_pay[i]});
                end else begin
                    bus.frame_n[i] = 1'b1;
                    bus.valid_n[i] = 1'b1;
                    bus.di[i]      = 1'b0;
                end
            end
        end
        @(negedge clock);
        bus.frame_n = '1;
        bus.valid_n = '1;
        bus.di      = '0;
    endtask

    function automatic bit model_idle();
        bit r = 1;
        for (int i = 0; i < NP; i++) begin
            if (capq[i].size() != 0 || m_hvld[i] || m_fifo[i].size() != 0 || m_left[i] != 0 || expq[i].size() != 0) r = 0;
        end
        return r;
    endfunction

    task automatic drain(input string name);
        bit done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clock);
            done = model_idle();
        end
        repeat (2) @(negedge clock);
        chk({name, "_drained"}, 64'(done), 64'd1);
        chk({name, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
    endtask

    initial begin
        bit seen;
        bus.frame_n = '1;
        bus.valid_n = '1;
        bus.di      = '0;
        repeat (3) @(negedge clock);
        chk("reset_frameo_n", 64'(bus.frameo_n), 64'hFF);
        chk("reset_valido_n", 64'(bus.valido_n), 64'hFF);
        chk("reset_dout", 64'(bus.dout), 64'h0);
        chk("reset_drop_cnt", 64'(drop_cnt), 64'h0);
        reset_n = 1'b1;

        // Single path 3 -> 5.
        clear_set();
        s_en[3] = 1; s_addr[3] = 5; s_pay[3] = 32'hDEADBEEF;
        send_set();
        drain("single");

        // Contention on output 1 from inputs 0, 2, 6, two bursts.
        for (int b = 0; b < 2; b++) begin
            clear_set();
            foreach (s_en[i]) if (i == 0 || i == 2 || i == 6) begin
                s_en[i] = 1; s_addr[i] = 1; s_pay[i] = $urandom;
            end
            send_set();
        end
        drain("contention");

        // Invalid address.
        clear_set();
        s_en[1] = 1; s_addr[1] = 12; s_pay[1] = 32'h12345678;
        send_set();
        drain("invalid_addr");

        // Back-pressure: every input floods output 4 twice.
        for (int b = 0; b < 2; b++) begin
            clear_set();
            for (int i = 0; i < NP; i++) begin
                s_en[i] = 1; s_addr[i] = 4; s_pay[i] = $urandom;
            end
            send_set();
        end
        drain("backpressure");

        // Parallel 0 -> 7 and 7 -> 0.
        clear_set();
        s_en[0] = 1; s_addr[0] = 7; s_pay[0] = 32'hA5A5_0007;
        s_en[7] = 1; s_addr[7] = 0; s_pay[7] = 32'h5A5A_0070;
        send_set();
        drain("parallel");

        // Random traffic with staggered starts and occasional invalid addresses.
        for (int r = 0; r < 25; r++) begin
            clear_set();
            for (int i = 0; i < NP; i++) begin
                s_en[i]   = ($urandom_range(0, 1) == 1);
                s_addr[i] = $urandom_range(0, 10);
                s_pay[i]  = $urandom;
                s_off[i]  = $urandom_range(0, 6);
            end
            send_set();
            if (r % 5 == 4) drain("random");
        end
        drain("random_final");

        // Reset in the middle of a frame on output 2.
        clear_set();
        s_en[0] = 1; s_addr[0] = 2; s_pay[0] = 32'hCAFEF00D;
        send_set();
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clock);
            seen = (bus.frameo_n[2] == 1'b0);
        end
        chk("reset_frame_started", 64'(seen), 64'd1);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_frameo_n2", 64'(bus.frameo_n[2]), 64'd1);
        chk("midreset_valido_n2", 64'(bus.valido_n[2]), 64'd1);
        chk("midreset_dout", 64'(bus.dout), 64'd0);
        chk("midreset_drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Normal routing after reset.
        clear_set();
        s_en[5] = 1; s_addr[5] = 3; s_pay[5] = 32'h0BADF00D;
        send_set();
        drain("after_reset");
        chk("final_frameo_n", 64'(bus.frameo_n), 64'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
